// File: rtl/uart_mem_loader_if.sv
// Byte-stream input and memory-write output of the UART memory loader.
// The master modport is the loader side; the slave modport is the UART/memory side.
interface uart_mem_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  mem_write;
  logic [3:0]            mem_wmask;
  logic [31:0]           mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    input  rx_valid, rx_data,
    output mem_write, mem_wmask, mem_wdata, mem_addr, busy, done, error
  );

  modport slave (
    output rx_valid, rx_data,
    input  mem_write, mem_wmask, mem_wdata, mem_addr, busy, done, error
  );
endinterface

// File: rtl/uart_mem_loader.sv
// Parses framed UART bytes (sync, address, length, payload, checksum) and
// writes the payload into word-addressed memory with byte-lane masks.
module uart_mem_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int TIMEOUT    = 1_200_000
) (
  input logic               clk,
  input logic               rst,
  uart_mem_loader_if.master bus
);
  localparam int         IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [7:0] SYNC_BYTE = 8'h55;

  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, DONE, ERR} state_t;

  state_t                state_q, state_d;
  logic [31:0]           byte_cnt_q, byte_cnt_d;   // byte index within the current field
  logic [23:0]           addr_q, addr_d;           // first three load-address bytes
  logic [31:0]           len_q, len_d;             // payload length, shifted in LE
  logic [7:0]            csum_q, csum_d;
  logic [23:0]           wbuf_q, wbuf_d;           // lanes 0..2 of the word being assembled
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                  mem_write_q, mem_write_d;
  logic [3:0]            mem_wmask_q, mem_wmask_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [31:0] addr_new;
  logic [31:0] len_new;
  logic [31:0] word_new;
  logic [1:0]  lane;
  logic        last_byte;
  logic        in_frame;

  assign lane      = byte_cnt_q[1:0];
  assign addr_new  = {bus.rx_data, addr_q};
  assign len_new   = {bus.rx_data, len_q[31:8]};
  assign last_byte = (byte_cnt_q == len_q - 32'd1);
  assign in_frame  = (state_q == ADDR) || (state_q == LEN) ||
                     (state_q == DATA) || (state_q == CSUM);
  // Lane 0 starts a fresh word so unfilled upper lanes are always zero.
  assign word_new  = (lane == 2'd0) ? {24'd0, bus.rx_data}
                                    : ({8'd0, wbuf_q} | ({24'd0, bus.rx_data} << {lane, 3'b000}));

  // Next-state and datapath: frame parsing, word packing, idle timeout.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    csum_d      = csum_q;
    wbuf_d      = wbuf_q;
    idle_cnt_d  = idle_cnt_q;
    mem_write_d = 1'b0;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    // The address advances once the write pulse has been presented.
    mem_addr_d  = mem_write_q ? mem_addr_q + ADDR_WIDTH'(1) : mem_addr_q;

    if (in_frame) begin
      if (bus.rx_valid) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
        idle_cnt_d = '0;
        state_d    = ERR;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end

    if (bus.rx_valid) begin
      case (state_q)
        ADDR: begin
          addr_d     = addr_new[31:8];
          byte_cnt_d = byte_cnt_q + 32'd1;
          if (lane == 2'd3) begin
            byte_cnt_d = '0;
            mem_addr_d = addr_new[ADDR_WIDTH+1:2];
            state_d    = (addr_new[1:0] != 2'b00) ? ERR : LEN;
          end
        end
        LEN: begin
          len_d      = len_new;
          byte_cnt_d = byte_cnt_q + 32'd1;
          if (lane == 2'd3) begin
            byte_cnt_d = '0;
            state_d    = (len_new == 32'd0) ? CSUM : DATA;
          end
        end
        DATA: begin
          csum_d     = csum_q + bus.rx_data;
          byte_cnt_d = byte_cnt_q + 32'd1;
          wbuf_d     = word_new[23:0];
          if ((lane == 2'd3) || last_byte) begin
            mem_write_d = 1'b1;
            mem_wdata_d = word_new;
            case (lane)
              2'd0:    mem_wmask_d = 4'b0001;
              2'd1:    mem_wmask_d = 4'b0011;
              2'd2:    mem_wmask_d = 4'b0111;
              default: mem_wmask_d = 4'b1111;
            endcase
          end
          if (last_byte) begin
            state_d = CSUM;
          end
        end
        CSUM: begin
          state_d = (bus.rx_data == csum_q) ? DONE : ERR;
        end
        default: begin
          // IDLE, DONE, ERR: only a sync byte starts a new frame.
          if (bus.rx_data == SYNC_BYTE) begin
            state_d    = ADDR;
            byte_cnt_d = '0;
            csum_d     = '0;
            idle_cnt_d = '0;
          end
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      wbuf_q      <= '0;
      idle_cnt_q  <= '0;
      mem_write_q <= 1'b0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      wbuf_q      <= wbuf_d;
      idle_cnt_q  <= idle_cnt_d;
      mem_write_q <= mem_write_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign bus.mem_write = mem_write_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.busy      = in_frame;
  assign bus.done      = (state_q == DONE);
  assign bus.error     = (state_q == ERR);
endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: frames are sent back-to-back, writes
// are logged on the falling edge and compared against hand-computed values.
module tb_uart_mem_loader;
  localparam int AW  = 14;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_mem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  uart_mem_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0]    tx_q[$];
  logic [AW-1:0] wr_addr[$];
  logic [3:0]    wr_mask[$];
  logic [31:0]   wr_data[$];

  // Write log: one entry per cycle with mem_write high.
  always @(negedge clk) begin
    if (bus.mem_write === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_mask.push_back(bus.mem_wmask);
      wr_data.push_back(bus.mem_wdata);
      $display("write addr=%h mask=%b data=%h", bus.mem_addr, bus.mem_wmask, bus.mem_wdata);
    end
  end

  task automatic put(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic q_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
  endtask

  // Queue sync, address, length and npay payload bytes first, first+step, ...
  task automatic q_frame(input logic [31:0] addr, input logic [31:0] len,
                         input logic [7:0] first, input logic [7:0] step, input int npay);
    logic [7:0] b;
    tx_q.push_back(8'h55);
    q_word(addr);
    q_word(len);
    b = first;
    for (int i = 0; i < npay; i++) begin
      tx_q.push_back(b);
      b = b + step;
    end
  endtask

  task automatic send_q();
    while (tx_q.size() > 0) put(tx_q.pop_front());
    bus.rx_valid = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_mask.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    n_vec++; if (bus.mem_write !== 1'b0) begin n_miss++; $display("FAIL reset mem_write: got %b want 0", bus.mem_write); end
    n_vec++; if (bus.mem_wmask !== 4'b0) begin n_miss++; $display("FAIL reset mem_wmask: got %b want 0000", bus.mem_wmask); end
    n_vec++; if (bus.mem_wdata !== 32'h0) begin n_miss++; $display("FAIL reset mem_wdata: got %h want 0", bus.mem_wdata); end
    n_vec++; if (bus.mem_addr !== '0) begin n_miss++; $display("FAIL reset mem_addr: got %h want 0", bus.mem_addr); end
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_miss++; $display("FAIL reset done: got %b want 0", bus.done); end
    n_vec++; if (bus.error !== 1'b0) begin n_miss++; $display("FAIL reset error: got %b want 0", bus.error); end
  endtask

  task automatic test_full_words();
    logic [AW-1:0] ea[2];
    logic [31:0]   ed[2];
    ea[0] = 14'h0040; ed[0] = 32'h44332211;
    ea[1] = 14'h0041; ed[1] = 32'h88776655;
    clear_log();
    q_frame(32'h0000_0100, 32'd8, 8'h11, 8'h11, 8);
    tx_q.push_back(8'h64);
    send_q();
    idle(2);
    n_vec++; if (wr_addr.size() != 2) begin n_miss++; $display("FAIL full_words count: got %0d want 2", wr_addr.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < wr_addr.size()) begin
        n_vec++; if (wr_addr[i] !== ea[i]) begin n_miss++; $display("FAIL full_words addr%0d: got %h want %h", i, wr_addr[i], ea[i]); end
        n_vec++; if (wr_mask[i] !== 4'b1111) begin n_miss++; $display("FAIL full_words mask%0d: got %b want 1111", i, wr_mask[i]); end
        n_vec++; if (wr_data[i] !== ed[i]) begin n_miss++; $display("FAIL full_words data%0d: got %h want %h", i, wr_data[i], ed[i]); end
      end
    end
    n_vec++; if (bus.done !== 1'b1) begin n_miss++; $display("FAIL full_words done: got %b want 1", bus.done); end
    n_vec++; if (bus.error !== 1'b0) begin n_miss++; $display("FAIL full_words error: got %b want 0", bus.error); end
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL full_words busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_partial_tail();
    logic [AW-1:0] ea[2];
    logic [3:0]    em[2];
    logic [31:0]   ed[2];
    ea[0] = 14'h0040; em[0] = 4'b1111; ed[0] = 32'h04030201;
    ea[1] = 14'h0041; em[1] = 4'b0001; ed[1] = 32'h00000005;
    clear_log();
    q_frame(32'h0000_0100, 32'd5, 8'h01, 8'h01, 5);
    tx_q.push_back(8'h0F);
    send_q();
    idle(2);
    n_vec++; if (wr_addr.size() != 2) begin n_miss++; $display("FAIL partial_tail count: got %0d want 2", wr_addr.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < wr_addr.size()) begin
        n_vec++; if (wr_addr[i] !== ea[i]) begin n_miss++; $display("FAIL partial_tail addr%0d: got %h want %h", i, wr_addr[i], ea[i]); end
        n_vec++; if (wr_mask[i] !== em[i]) begin n_miss++; $display("FAIL partial_tail mask%0d: got %b want %b", i, wr_mask[i], em[i]); end
        n_vec++; if (wr_data[i] !== ed[i]) begin n_miss++; $display("FAIL partial_tail data%0d: got %h want %h", i, wr_data[i], ed[i]); end
      end
    end
    n_vec++; if (bus.done !== 1'b1) begin n_miss++; $display("FAIL partial_tail done: got %b want 1", bus.done); end
  endtask

  task automatic test_bad_addr();
    clear_log();
    tx_q.push_back(8'h55);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    send_q();
    n_vec++; if (bus.busy !== 1'b1) begin n_miss++; $display("FAIL bad_addr busy_mid: got %b want 1", bus.busy); end
    n_vec++; if (bus.error !== 1'b0) begin n_miss++; $display("FAIL bad_addr error_mid: got %b want 0", bus.error); end
    n_vec++; if (bus.done !== 1'b0) begin n_miss++; $display("FAIL bad_addr done_cleared: got %b want 0", bus.done); end
    put(8'h00);
    bus.rx_valid = 1'b0;
    n_vec++; if (bus.error !== 1'b1) begin n_miss++; $display("FAIL bad_addr error: got %b want 1", bus.error); end
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL bad_addr busy: got %b want 0", bus.busy); end
    idle(3);
    n_vec++; if (wr_addr.size() != 0) begin n_miss++; $display("FAIL bad_addr writes: got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_bad_csum();
    clear_log();
    q_frame(32'h0000_0100, 32'd8, 8'h11, 8'h11, 8);
    tx_q.push_back(8'h00);
    send_q();
    idle(2);
    n_vec++; if (wr_addr.size() != 2) begin n_miss++; $display("FAIL bad_csum count: got %0d want 2", wr_addr.size()); end
    n_vec++; if (bus.error !== 1'b1) begin n_miss++; $display("FAIL bad_csum error: got %b want 1", bus.error); end
    n_vec++; if (bus.done !== 1'b0) begin n_miss++; $display("FAIL bad_csum done: got %b want 0", bus.done); end
  endtask

  task automatic test_timeout();
    clear_log();
    q_frame(32'h0000_0100, 32'd8, 8'h11, 8'h11, 2);
    send_q();
    n_vec++; if (bus.error !== 1'b0) begin n_miss++; $display("FAIL timeout error_cleared: got %b want 0", bus.error); end
    idle(TMO - 1);
    n_vec++; if (bus.error !== 1'b0) begin n_miss++; $display("FAIL timeout early_error: got %b want 0", bus.error); end
    n_vec++; if (bus.busy !== 1'b1) begin n_miss++; $display("FAIL timeout early_busy: got %b want 1", bus.busy); end
    idle(1);
    n_vec++; if (bus.error !== 1'b1) begin n_miss++; $display("FAIL timeout error: got %b want 1", bus.error); end
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL timeout busy: got %b want 0", bus.busy); end
    idle(3);
    n_vec++; if (wr_addr.size() != 0) begin n_miss++; $display("FAIL timeout writes: got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_back_to_back_reset();
    logic [AW-1:0] ea[2];
    logic [31:0]   ed[2];
    ea[0] = 14'h0080; ed[0] = 32'h44332211;
    ea[1] = 14'h0081; ed[1] = 32'h88776655;
    clear_log();
    q_frame(32'h0000_0100, 32'd8, 8'h11, 8'h11, 6);
    send_q();
    n_vec++; if (wr_addr.size() != 1) begin n_miss++; $display("FAIL b2b_reset pre_writes: got %0d want 1", wr_addr.size()); end
    #1 rst = 1'b1;
    #2;
    n_vec++; if (bus.mem_write !== 1'b0) begin n_miss++; $display("FAIL b2b_reset mem_write: got %b want 0", bus.mem_write); end
    n_vec++; if (bus.mem_wmask !== 4'b0) begin n_miss++; $display("FAIL b2b_reset mem_wmask: got %b want 0000", bus.mem_wmask); end
    n_vec++; if (bus.mem_wdata !== 32'h0) begin n_miss++; $display("FAIL b2b_reset mem_wdata: got %h want 0", bus.mem_wdata); end
    n_vec++; if (bus.mem_addr !== '0) begin n_miss++; $display("FAIL b2b_reset mem_addr: got %h want 0", bus.mem_addr); end
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL b2b_reset busy: got %b want 0", bus.busy); end
    n_vec++; if ({bus.done, bus.error} !== 2'b00) begin n_miss++; $display("FAIL b2b_reset flags: got %b want 00", {bus.done, bus.error}); end
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    put(8'h77);
    put(8'h88);
    idle(2);
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL b2b_reset ignored_bytes busy: got %b want 0", bus.busy); end
    n_vec++; if (wr_addr.size() != 0) begin n_miss++; $display("FAIL b2b_reset partial_write: got %0d want 0", wr_addr.size()); end
    q_frame(32'h0000_0200, 32'd8, 8'h11, 8'h11, 8);
    tx_q.push_back(8'h64);
    send_q();
    idle(2);
    n_vec++; if (wr_addr.size() != 2) begin n_miss++; $display("FAIL b2b_reset count: got %0d want 2", wr_addr.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < wr_addr.size()) begin
        n_vec++; if (wr_addr[i] !== ea[i]) begin n_miss++; $display("FAIL b2b_reset addr%0d: got %h want %h", i, wr_addr[i], ea[i]); end
        n_vec++; if (wr_data[i] !== ed[i]) begin n_miss++; $display("FAIL b2b_reset data%0d: got %h want %h", i, wr_data[i], ed[i]); end
      end
    end
    n_vec++; if (bus.done !== 1'b1) begin n_miss++; $display("FAIL b2b_reset done: got %b want 1", bus.done); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea[2];
    logic [31:0]   ed[2];
    ea[0] = 14'h3FFF; ed[0] = 32'h04030201;
    ea[1] = 14'h0000; ed[1] = 32'h08070605;
    clear_log();
    q_frame(32'h0003_FFFC, 32'd8, 8'h01, 8'h01, 8);
    tx_q.push_back(8'h24);
    send_q();
    idle(2);
    n_vec++; if (wr_addr.size() != 2) begin n_miss++; $display("FAIL wrap count: got %0d want 2", wr_addr.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < wr_addr.size()) begin
        n_vec++; if (wr_addr[i] !== ea[i]) begin n_miss++; $display("FAIL wrap addr%0d: got %h want %h", i, wr_addr[i], ea[i]); end
        n_vec++; if (wr_data[i] !== ed[i]) begin n_miss++; $display("FAIL wrap data%0d: got %h want %h", i, wr_data[i], ed[i]); end
      end
    end
    n_vec++; if (bus.done !== 1'b1) begin n_miss++; $display("FAIL wrap done: got %b want 1", bus.done); end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    idle(2);
    test_reset();
    test_full_words();
    test_partial_tail();
    test_bad_addr();
    test_bad_csum();
    test_timeout();
    test_back_to_back_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
